// File: rtl/serializer.sv
// serializer
// Parallel-to-serial converter: DATA_W-bit words leave MSB first, one bit per
// cycle, with a per-bit valid strobe. A small circular buffer in front of the
// shifter lets the source queue words while the previous word is shifting out.
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous reset, active low
//   data_i          parallel word, bit DATA_W-1 leaves first
//   data_mod_i      valid bits counted from the MSB, 0 means DATA_W
//   data_val_i      word valid
//   data_ready_o    buffer can accept a word (registered)
//   ser_data_o      serial bit (registered, 0 when not valid)
//   ser_data_val_o  serial bit valid (registered)
//   busy_o          a word is shifting or the buffer holds words
module serializer #(
  parameter int DATA_W    = 16,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = MOD_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } entry_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  entry_t             mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q;

  state_t             state_q;
  logic [DATA_W-1:0]  shreg_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               ser_data_q, ser_val_q;

  logic [LEN_W-1:0]   len_in;
  logic               drop, push, pop, buf_nempty, last_bit;
  entry_t             head;

  // Length 1 or 2 words complete the handshake but never reach the buffer.
  assign len_in     = (data_mod_i == '0) ? LEN_W'(DATA_W) : {1'b0, data_mod_i};
  assign drop       = (len_in <= LEN_W'(2));
  assign push       = data_val_i && ready_q && !drop;
  assign buf_nempty = (count_q != '0);
  assign last_bit   = (cnt_q == LEN_W'(1));
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = buf_nempty;
      SHIFT:   pop = last_bit && buf_nempty;
      default: pop = 1'b0;
    endcase
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Buffer storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{data: data_i, len: len_in};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      // Ready reflects post-edge occupancy; a pop from a full buffer only
      // reopens the slot for the following edge.
      ready_q <= (count_d != CNT_W'(BUF_DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (pop) begin
        // Loading presents the first bit straight away; cnt counts the bits
        // still owed including the one on the output.
        state_q    <= SHIFT;
        ser_data_q <= head.data[DATA_W-1];
        ser_val_q  <= 1'b1;
        shreg_q    <= {head.data[DATA_W-2:0], 1'b0};
        cnt_q      <= head.len;
      end else if (state_q == SHIFT && !last_bit) begin
        ser_data_q <= shreg_q[DATA_W-1];
        ser_val_q  <= 1'b1;
        shreg_q    <= {shreg_q[DATA_W-2:0], 1'b0};
        cnt_q      <= cnt_q - LEN_W'(1);
      end else begin
        state_q    <= IDLE;
        ser_data_q <= 1'b0;
        ser_val_q  <= 1'b0;
        cnt_q      <= '0;
      end
    end
  end

  assign data_ready_o   = ready_q;
  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = (state_q == SHIFT) || buf_nempty;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed cases plus random words, with
// expected bits queued by a word-level model and checked by a monitor.
module tb_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        data_ready_o, ser_data_o, ser_data_val_o, busy_o;

  serializer #(.DATA_W(16), .MOD_W(4), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .data_ready_o(data_ready_o), .ser_data_o(ser_data_o),
    .ser_data_val_o(ser_data_val_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int   errs = 0;
  int   checks = 0;
  logic exp_q[$];
  int   runs[$];
  int   cur_run = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a word of length L contributes its top L bits, MSB first;
  // lengths 1 and 2 contribute nothing.
  task automatic model_push(input logic [15:0] d, input logic [3:0] m);
    int len;
    len = (m == 0) ? 16 : int'(m);
    if (len >= 3)
      for (int i = 0; i < len; i++) exp_q.push_back(d[15-i]);
  endtask

  // Call at a negedge; leaves data_val_i high so calls can run back to back.
  task automatic send(input logic [15:0] d, input logic [3:0] m, output bit acc);
    acc = 1'b0;
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = data_ready_o;
      @(negedge clk);
    end
    if (acc) model_push(d, m);
    else check("send_timeout", 0, 1);
  endtask

  task automatic wait_run(output int len);
    len = -1;
    for (int t = 0; t < 100 && runs.size() == 0; t++) @(negedge clk);
    if (runs.size() != 0) len = runs.pop_front();
  endtask

  // Monitor: every valid bit must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) cur_run = 0;
    else if (ser_data_val_o) begin
      cur_run++;
      if (exp_q.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_bit: got %0b expected none at %0t", ser_data_o, $time);
      end else check("ser_bit", ser_data_o, exp_q.pop_front());
    end else begin
      if (cur_run != 0) runs.push_back(cur_run);
      cur_run = 0;
      check("idle_data_zero", ser_data_o, 0);
    end
  end

  initial begin
    bit acc;
    int len, n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", data_ready_o, 0);
    check("rst_val", ser_data_val_o, 0);
    check("rst_data", ser_data_o, 0);
    check("rst_busy", busy_o, 0);
    #2 rst_n = 1'b1;
    #1 check("ready_before_edge", data_ready_o, 0);
    @(negedge clk);
    check("ready_after_release", data_ready_o, 1);

    // Single full word: latency and run length
    send(16'hA5C3, 4'd0, acc);
    data_val_i = 1'b0;
    check("lat_pre_val", ser_data_val_o, 0);
    check("lat_pre_busy", busy_o, 1);
    @(negedge clk);
    check("lat_first_val", ser_data_val_o, 1);
    wait_run(len);
    check("full_run_len", len, 16);
    check("busy_after_word", busy_o, 0);

    // Short word
    send(16'hDFFF, 4'd3, acc);
    data_val_i = 1'b0;
    wait_run(len);
    check("short_run_len", len, 3);

    // Dropped lengths
    send(16'hFFFF, 4'd1, acc);
    check("drop1_accept", acc, 1);
    send(16'hFFFF, 4'd2, acc);
    check("drop2_accept", acc, 1);
    data_val_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("drop_val", ser_data_val_o, 0);
      check("drop_busy", busy_o, 0);
    end

    // Back-to-back, full buffer, ignored valid
    runs.delete();
    send(16'hF000, 4'd4, acc);
    send(16'h0000, 4'd4, acc);
    send(16'hA000, 4'd4, acc);
    check("full_ready_low", data_ready_o, 0);
    data_i = 16'hFFFF; data_mod_i = 4'd0;
    @(negedge clk);
    data_val_i = 1'b0;
    wait_run(len);
    check("b2b_run_len", len, 12);
    repeat (5) @(negedge clk);
    check("b2b_drained", exp_q.size(), 0);
    check("ignored_busy", busy_o, 0);

    // Reset mid-word with one word queued
    send(16'h1234, 4'd0, acc);
    send(16'hFEDC, 4'd0, acc);
    data_val_i = 1'b0;
    n = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      if (ser_data_val_o) n++;
      if (n < 5) @(negedge clk);
    end
    check("mid_bits_seen", n, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_val", ser_data_val_o, 0);
    check("mid_rst_data", ser_data_o, 0);
    check("mid_rst_ready", data_ready_o, 0);
    check("mid_rst_busy", busy_o, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", data_ready_o, 1);
    check("rel_busy", busy_o, 0);
    runs.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rel_no_bits", ser_data_val_o, 0);
    end

    // Random words, random lengths, random gaps
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 4'($urandom_range(0, 15)), acc);
      if ($urandom_range(0, 3) == 0) begin
        data_val_i = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
    end
    data_val_i = 1'b0;
    for (int t = 0; t < 3000 && (exp_q.size() != 0 || busy_o); t++) @(negedge clk);
    @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    check("final_busy", busy_o, 0);
    check("final_ready", data_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
